// File: rtl/spi_burst_master.sv
// spi_burst_master: SPI master for BMP280-class sensors (mode 0 / mode 3).
// A frame is one command word followed by 0..MAX_BYTES data bytes under a
// single csb assertion. sck changes data on its falling edge and samples
// on its rising edge. CPOL only sets the idle level of sck.
// Ports:
//   clk12MHz, rst          : clock (rising edge), async active-high reset
//   go                     : start request, sampled when idle
//   cmd, nbytes, wdata     : frame contents, latched when go is accepted
//   sdi / sdo, sck, csb    : SPI pins
//   rdata                  : received data bytes, right-justified, updated with done
//   busy, done             : frame in progress / one-cycle completion pulse
module spi_burst_master #(
  parameter int unsigned CMD_BITS  = 8,
  parameter int unsigned MAX_BYTES = 3,
  parameter int unsigned CLK_DIV   = 3,
  parameter bit          CPOL      = 1'b0
) (
  input  logic                           clk12MHz,
  input  logic                           rst,
  input  logic                           go,
  input  logic [CMD_BITS-1:0]            cmd,
  input  logic [$clog2(MAX_BYTES+1)-1:0] nbytes,
  input  logic [8*MAX_BYTES-1:0]         wdata,
  input  logic                           sdi,
  output logic                           sdo,
  output logic                           sck,
  output logic                           csb,
  output logic [8*MAX_BYTES-1:0]         rdata,
  output logic                           busy,
  output logic                           done
);

  localparam int unsigned NB_W   = $clog2(MAX_BYTES + 1);
  localparam int unsigned DATA_W = 8 * MAX_BYTES;
  localparam int unsigned SH_W   = CMD_BITS + DATA_W;
  localparam int unsigned BC_W   = $clog2(SH_W + 1);
  localparam int unsigned DC_W   = $clog2(CLK_DIV + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t              state_q, state_d;
  logic [DC_W-1:0]     div_q, div_d;
  logic [BC_W-1:0]     bit_q, bit_d;
  logic [BC_W-1:0]     blen_q, blen_d;
  logic [NB_W-1:0]     nb_q, nb_d;
  logic                phase_q, phase_d;   // 0: sck-low half, 1: sck-high half
  logic [SH_W-1:0]     sh_q, sh_d;         // outgoing bits, next bit at MSB
  logic [DATA_W-1:0]   rx_q, rx_d;         // last DATA_W captured sdi bits
  logic                sdo_d, sck_d, csb_d, busy_d, done_d;
  logic [DATA_W-1:0]   rdata_d;

  logic [NB_W-1:0]     nb_clamp_c;
  logic [DATA_W-1:0]   wdata_al_c;
  logic [DATA_W-1:0]   rdata_mask_c;
  logic                div_end_c;
  logic                bit_last_c;
  logic                start_c;

  // Clamp the byte count and left-align the data bytes behind the command
  always_comb begin
    nb_clamp_c = (32'(nbytes) > MAX_BYTES) ? NB_W'(MAX_BYTES) : nbytes;
    wdata_al_c = wdata << (8 * (MAX_BYTES - 32'(nb_clamp_c)));
  end

  // Keep only the bytes belonging to the data phase of the finished frame
  always_comb begin
    rdata_mask_c = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (32'(nb_q) > i) rdata_mask_c[8*i +: 8] = rx_q[8*i +: 8];
    end
  end

  assign div_end_c  = (div_q == DC_W'(CLK_DIV - 1));
  assign bit_last_c = (bit_q == blen_q - BC_W'(1));

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    blen_d  = blen_q;
    nb_d    = nb_q;
    phase_d = phase_q;
    sh_d    = sh_q;
    rx_d    = rx_q;
    sdo_d   = sdo;
    sck_d   = sck;
    csb_d   = csb;
    busy_d  = busy;
    done_d  = 1'b0;
    rdata_d = rdata;
    start_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (go) start_c = 1'b1;
      end
      SETUP: begin
        if (div_end_c) begin
          state_d = SHIFT;
          div_d   = '0;
          phase_d = 1'b0;
          sck_d   = 1'b0;
        end else begin
          div_d = div_q + DC_W'(1);
        end
      end
      SHIFT: begin
        if (!div_end_c) begin
          div_d = div_q + DC_W'(1);
        end else begin
          div_d = '0;
          if (!phase_q) begin
            // rising sck: sample the slave
            phase_d = 1'b1;
            sck_d   = 1'b1;
            rx_d    = {rx_q[DATA_W-2:0], sdi};
          end else if (bit_last_c) begin
            state_d = HOLD;
            bit_d   = '0;
            phase_d = 1'b0;
            sck_d   = CPOL;
            sdo_d   = 1'b0;
          end else begin
            // falling sck: present the next bit
            phase_d = 1'b0;
            sck_d   = 1'b0;
            bit_d   = bit_q + BC_W'(1);
            sh_d    = {sh_q[SH_W-2:0], 1'b0};
            sdo_d   = sh_q[SH_W-2];
          end
        end
      end
      HOLD: begin
        if (div_end_c) begin
          state_d = GAP;
          div_d   = '0;
          csb_d   = 1'b1;
        end else begin
          div_d = div_q + DC_W'(1);
        end
      end
      GAP: begin
        if (div_end_c) begin
          state_d = IDLE;
          div_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rdata_d = rdata_mask_c;
          // a go already present here chains the next frame with a CLK_DIV csb gap
          if (go) start_c = 1'b1;
        end else begin
          div_d = div_q + DC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_c) begin
      state_d = SETUP;
      div_d   = '0;
      bit_d   = '0;
      phase_d = 1'b0;
      nb_d    = nb_clamp_c;
      blen_d  = BC_W'(CMD_BITS + 8 * 32'(nb_clamp_c));
      sh_d    = {cmd, wdata_al_c};
      rx_d    = '0;
      sdo_d   = cmd[CMD_BITS-1];
      sck_d   = CPOL;
      csb_d   = 1'b0;
      busy_d  = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clk12MHz or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      blen_q  <= '0;
      nb_q    <= '0;
      phase_q <= 1'b0;
      sh_q    <= '0;
      rx_q    <= '0;
      sdo     <= 1'b0;
      sck     <= CPOL;
      csb     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      blen_q  <= blen_d;
      nb_q    <= nb_d;
      phase_q <= phase_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      sdo     <= sdo_d;
      sck     <= sck_d;
      csb     <= csb_d;
      busy    <= busy_d;
      done    <= done_d;
      rdata   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_spi_burst_master.sv
// Bench for spi_burst_master: unit 0 runs mode 0, unit 1 runs mode 3, both
// with CLK_DIV=2. A slave model per unit serves a 32-bit response stream
// MSB first and records sdo on every sck rising edge.
module tb_spi_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cmd;
  logic [1:0]  nbytes;
  logic [23:0] wdata;
  logic        go_v    [2];
  logic        sdi_v   [2];
  logic        sdo_v   [2];
  logic        sck_v   [2];
  logic        csb_v   [2];
  logic [23:0] rdata_v [2];
  logic        busy_v  [2];
  logic        done_v  [2];

  int n_cmp = 0;
  int n_bad = 0;

  // slave/monitor state
  logic [31:0] resp     [2];
  logic [31:0] mosi     [2];
  int          idx      [2];
  int          edges    [2];
  int          done_cnt [2];
  int          hi_run   [2];
  int          last_gap [2];
  logic        prev_sck [2];
  logic        prev_csb [2];
  int          cyc = 0;

  always #5 clk = ~clk;

  spi_burst_master #(.CMD_BITS(8), .MAX_BYTES(3), .CLK_DIV(2), .CPOL(1'b0)) u0 (
    .clk12MHz(clk), .rst(rst), .go(go_v[0]), .cmd(cmd), .nbytes(nbytes), .wdata(wdata),
    .sdi(sdi_v[0]), .sdo(sdo_v[0]), .sck(sck_v[0]), .csb(csb_v[0]), .rdata(rdata_v[0]),
    .busy(busy_v[0]), .done(done_v[0]));

  spi_burst_master #(.CMD_BITS(8), .MAX_BYTES(3), .CLK_DIV(2), .CPOL(1'b1)) u1 (
    .clk12MHz(clk), .rst(rst), .go(go_v[1]), .cmd(cmd), .nbytes(nbytes), .wdata(wdata),
    .sdi(sdi_v[1]), .sdo(sdo_v[1]), .sck(sck_v[1]), .csb(csb_v[1]), .rdata(rdata_v[1]),
    .busy(busy_v[1]), .done(done_v[1]));

  // Slave drives the current stream bit until the next sck rising edge
  always_comb begin
    for (int u = 0; u < 2; u++)
      sdi_v[u] = (idx[u] < 32) ? resp[u][5'(31 - idx[u])] : 1'b0;
  end

  // Monitor sampled 2 ns after each rising clk edge
  always begin
    @(posedge clk);
    #2;
    cyc++;
    for (int u = 0; u < 2; u++) begin
      if (prev_csb[u] && !csb_v[u]) begin
        idx[u] = 0; edges[u] = 0; mosi[u] = '0; last_gap[u] = hi_run[u];
      end
      if (csb_v[u]) hi_run[u]++; else hi_run[u] = 0;
      if (!prev_sck[u] && sck_v[u] && !csb_v[u]) begin
        mosi[u] = {mosi[u][30:0], sdo_v[u]};
        edges[u]++;
        idx[u]++;
      end
      if (done_v[u]) done_cnt[u]++;
      prev_sck[u] = sck_v[u];
      prev_csb[u] = csb_v[u];
    end
  end

  // Reference: sdo stream is cmd followed by the n low bytes of wdata, top byte first
  function automatic logic [31:0] exp_mosi(input logic [7:0] c, input int n, input logic [23:0] w);
    logic [31:0] s;
    s = 32'(c);
    for (int j = n - 1; j >= 0; j--) s = (s << 8) | 32'((w >> (8 * j)) & 24'hFF);
    return s;
  endfunction

  // Reference: received data is the last 8n bits of the B-bit slave stream
  function automatic logic [23:0] exp_rd(input int n, input logic [31:0] r);
    int          b;
    logic [31:0] s;
    b = 8 + 8 * n;
    s = r >> (32 - b);
    return (n == 0) ? 24'h0 : 24'(s & ((32'h1 << (8 * n)) - 32'h1));
  endfunction

  function automatic int exp_lat(input int n);
    return 2 * (3 + 2 * (8 + 8 * n));
  endfunction

  // Run one frame on unit u; optionally pulse go again pulse_at cycles in
  task automatic run_frame(input int u, input logic [7:0] c, input logic [1:0] n,
                           input logic [23:0] w, input logic [31:0] r, input int pulse_at,
                           output int lat, output int edg, output logic [31:0] mo,
                           output logic [23:0] rd, output logic bsy, output logic tmo);
    int acc;
    @(negedge clk);
    cmd = c; nbytes = n; wdata = w; resp[u] = r; go_v[u] = 1'b1;
    @(negedge clk);
    acc = cyc; bsy = busy_v[u]; go_v[u] = 1'b0;
    cmd = 8'($urandom); nbytes = 2'($urandom); wdata = 24'($urandom);
    tmo = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      go_v[u] = (k == pulse_at);
      if (done_v[u]) begin tmo = 1'b0; break; end
    end
    go_v[u] = 1'b0;
    lat = cyc - acc; edg = edges[u]; mo = mosi[u]; rd = rdata_v[u];
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      n_cmp++; if (csb_v[u] !== 1'b1) begin n_bad++; $display("FAIL reset_csb u%0d: got %b want 1", u, csb_v[u]); end
      n_cmp++; if (sck_v[u] !== 1'(u)) begin n_bad++; $display("FAIL reset_sck u%0d: got %b want %0d", u, sck_v[u], u); end
      n_cmp++; if (sdo_v[u] !== 1'b0) begin n_bad++; $display("FAIL reset_sdo u%0d: got %b want 0", u, sdo_v[u]); end
      n_cmp++; if (busy_v[u] !== 1'b0 || done_v[u] !== 1'b0) begin n_bad++; $display("FAIL reset_busy_done u%0d: got %b%b want 00", u, busy_v[u], done_v[u]); end
      n_cmp++; if (rdata_v[u] !== 24'h0) begin n_bad++; $display("FAIL reset_rdata u%0d: got %h want 000000", u, rdata_v[u]); end
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++; if (edges[0] + edges[1] + done_cnt[0] + done_cnt[1] !== 0) begin n_bad++; $display("FAIL idle_activity: got %0d events want 0", edges[0] + edges[1] + done_cnt[0] + done_cnt[1]); end
    n_cmp++; if (csb_v[0] !== 1'b1 || csb_v[1] !== 1'b1) begin n_bad++; $display("FAIL idle_csb: got %b%b want 11", csb_v[0], csb_v[1]); end
  endtask

  task automatic test_chip_id;
    int lat, edg; logic [31:0] mo; logic [23:0] rd; logic bsy, tmo;
    run_frame(0, 8'hD0, 2'd1, 24'h0, {8'($urandom), 8'h58, 16'($urandom)}, -1, lat, edg, mo, rd, bsy, tmo);
    n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL chipid_timeout: got %b want 0", tmo); end
    n_cmp++; if (bsy !== 1'b1) begin n_bad++; $display("FAIL chipid_busy: got %b want 1", bsy); end
    n_cmp++; if (lat !== 70) begin n_bad++; $display("FAIL chipid_latency: got %0d want 70", lat); end
    n_cmp++; if (edg !== 16) begin n_bad++; $display("FAIL chipid_edges: got %0d want 16", edg); end
    n_cmp++; if (mo !== 32'h0000D000) begin n_bad++; $display("FAIL chipid_sdo: got %h want 0000d000", mo); end
    n_cmp++; if (rd !== 24'h000058) begin n_bad++; $display("FAIL chipid_rdata: got %h want 000058", rd); end
    @(negedge clk);
    n_cmp++; if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin n_bad++; $display("FAIL chipid_done_pulse: got done=%b busy=%b want 0 0", done_v[0], busy_v[0]); end
    n_cmp++; if (rdata_v[0] !== 24'h000058) begin n_bad++; $display("FAIL chipid_rdata_hold: got %h want 000058", rdata_v[0]); end
  endtask

  task automatic test_burst;
    int lat, edg; logic [31:0] mo; logic [23:0] rd; logic bsy, tmo;
    run_frame(0, 8'hFA, 2'd3, 24'h0, {8'($urandom), 24'h800000}, -1, lat, edg, mo, rd, bsy, tmo);
    n_cmp++; if (tmo !== 1'b0 || lat !== 134) begin n_bad++; $display("FAIL burst_latency: got %0d (timeout %b) want 134", lat, tmo); end
    n_cmp++; if (edg !== 32) begin n_bad++; $display("FAIL burst_edges: got %0d want 32", edg); end
    n_cmp++; if (rd !== 24'h800000) begin n_bad++; $display("FAIL burst_rdata: got %h want 800000", rd); end
  endtask

  task automatic test_write_clamp;
    int lat, edg; logic [31:0] mo; logic [23:0] rd; logic bsy, tmo;
    logic [2:0] big; logic [23:0] w; int nexp;
    run_frame(0, 8'h74, 2'd1, 24'h000027, 32'($urandom), -1, lat, edg, mo, rd, bsy, tmo);
    n_cmp++; if (mo !== 32'h00007427) begin n_bad++; $display("FAIL write_sdo: got %h want 00007427", mo); end
    big = 3'd7; w = 24'($urandom);
    nexp = (int'(big) > 3) ? 3 : int'(big);
    run_frame(0, 8'h74, 2'(big), w, 32'hA5C3_1E77, -1, lat, edg, mo, rd, bsy, tmo);
    n_cmp++; if (lat !== exp_lat(nexp)) begin n_bad++; $display("FAIL clamp_latency: got %0d want %0d", lat, exp_lat(nexp)); end
    n_cmp++; if (mo !== exp_mosi(8'h74, nexp, w)) begin n_bad++; $display("FAIL clamp_sdo: got %h want %h", mo, exp_mosi(8'h74, nexp, w)); end
    n_cmp++; if (rd !== exp_rd(nexp, 32'hA5C3_1E77)) begin n_bad++; $display("FAIL clamp_rdata: got %h want %h", rd, exp_rd(nexp, 32'hA5C3_1E77)); end
    run_frame(0, 8'hF3, 2'd0, 24'hFFFFFF, 32'hFFFF_FFFF, -1, lat, edg, mo, rd, bsy, tmo);
    n_cmp++; if (edg !== 8) begin n_bad++; $display("FAIL cmdonly_edges: got %0d want 8", edg); end
    n_cmp++; if (lat !== 38) begin n_bad++; $display("FAIL cmdonly_latency: got %0d want 38", lat); end
    n_cmp++; if (rd !== 24'h0) begin n_bad++; $display("FAIL cmdonly_rdata: got %h want 000000", rd); end
  endtask

  task automatic test_random;
    int lat, edg; logic [31:0] mo; logic [23:0] rd; logic bsy, tmo;
    int u, n; logic [7:0] c; logic [23:0] w; logic [31:0] r;
    for (int t = 0; t < 10; t++) begin
      u = int'($urandom_range(0, 1)); n = int'($urandom_range(0, 3));
      c = 8'($urandom); w = 24'($urandom); r = $urandom;
      run_frame(u, c, 2'(n), w, r, -1, lat, edg, mo, rd, bsy, tmo);
      n_cmp++; if (tmo !== 1'b0 || lat !== exp_lat(n)) begin n_bad++; $display("FAIL rand%0d_latency u%0d n%0d: got %0d want %0d", t, u, n, lat, exp_lat(n)); end
      n_cmp++; if (edg !== 8 + 8 * n) begin n_bad++; $display("FAIL rand%0d_edges: got %0d want %0d", t, edg, 8 + 8 * n); end
      n_cmp++; if (mo !== exp_mosi(c, n, w)) begin n_bad++; $display("FAIL rand%0d_sdo: got %h want %h", t, mo, exp_mosi(c, n, w)); end
      n_cmp++; if (rd !== exp_rd(n, r)) begin n_bad++; $display("FAIL rand%0d_rdata: got %h want %h", t, rd, exp_rd(n, r)); end
    end
  endtask

  task automatic test_handshake;
    int lat, edg; logic [31:0] mo; logic [23:0] rd; logic bsy, tmo;
    int d0, k; logic [31:0] r;
    d0 = done_cnt[0];
    run_frame(0, 8'hD0, 2'd1, 24'h0, 32'h1234_5678, 20, lat, edg, mo, rd, bsy, tmo);
    repeat (40) @(negedge clk);
    n_cmp++; if (done_cnt[0] - d0 !== 1) begin n_bad++; $display("FAIL midgo_frames: got %0d want 1", done_cnt[0] - d0); end
    n_cmp++; if (csb_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin n_bad++; $display("FAIL midgo_idle: got csb=%b busy=%b want 1 0", csb_v[0], busy_v[0]); end
    // go held high across done: the next frame follows with a short csb gap
    d0 = done_cnt[0]; r = {8'h00, 8'h58, 16'h0000};
    @(negedge clk);
    cmd = 8'hD0; nbytes = 2'd1; wdata = 24'h0; resp[0] = r; go_v[0] = 1'b1;
    k = 0;
    while (!done_v[0] && k < 400) begin @(negedge clk); k++; end
    go_v[0] = 1'b0;
    @(negedge clk);
    k = 0;
    while (!done_v[0] && k < 400) begin @(negedge clk); k++; end
    n_cmp++; if (k >= 400) begin n_bad++; $display("FAIL chain_timeout: got %0d cycles want <400", k); end
    n_cmp++; if (rdata_v[0] !== 24'h000058) begin n_bad++; $display("FAIL chain_rdata: got %h want 000058", rdata_v[0]); end
    repeat (10) @(negedge clk);
    n_cmp++; if (done_cnt[0] - d0 !== 2) begin n_bad++; $display("FAIL chain_frames: got %0d want 2", done_cnt[0] - d0); end
    n_cmp++; if (last_gap[0] !== 2) begin n_bad++; $display("FAIL chain_csb_gap: got %0d want 2", last_gap[0]); end
  endtask

  task automatic test_abort_mode3;
    int lat, edg; logic [31:0] mo; logic [23:0] rd; logic bsy, tmo;
    int d0, k;
    d0 = done_cnt[0];
    @(negedge clk);
    cmd = 8'hD0; nbytes = 2'd1; wdata = 24'h0; resp[0] = 32'hFFFF_FFFF; go_v[0] = 1'b1;
    @(negedge clk);
    go_v[0] = 1'b0;
    k = 0;
    while (edges[0] < 5 && k < 200) begin @(negedge clk); k++; end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (csb_v[0] !== 1'b1 || sck_v[0] !== 1'b0 || sdo_v[0] !== 1'b0) begin n_bad++; $display("FAIL abort_pins: got csb=%b sck=%b sdo=%b want 1 0 0", csb_v[0], sck_v[0], sdo_v[0]); end
    n_cmp++; if (busy_v[0] !== 1'b0 || rdata_v[0] !== 24'h0) begin n_bad++; $display("FAIL abort_state: got busy=%b rdata=%h want 0 000000", busy_v[0], rdata_v[0]); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    n_cmp++; if (done_cnt[0] !== d0 || csb_v[0] !== 1'b1) begin n_bad++; $display("FAIL abort_no_done: got dones=%0d csb=%b want %0d 1", done_cnt[0], csb_v[0], d0); end
    // mode 3 chip-ID read
    n_cmp++; if (sck_v[1] !== 1'b1) begin n_bad++; $display("FAIL mode3_idle_sck: got %b want 1", sck_v[1]); end
    run_frame(1, 8'hD0, 2'd1, 24'h0, {8'($urandom), 8'h58, 16'($urandom)}, -1, lat, edg, mo, rd, bsy, tmo);
    n_cmp++; if (tmo !== 1'b0 || lat !== 70) begin n_bad++; $display("FAIL mode3_latency: got %0d want 70", lat); end
    n_cmp++; if (edg !== 16 || mo !== 32'h0000D000) begin n_bad++; $display("FAIL mode3_sdo: got %0d edges %h want 16 0000d000", edg, mo); end
    n_cmp++; if (rd !== 24'h000058) begin n_bad++; $display("FAIL mode3_rdata: got %h want 000058", rd); end
    n_cmp++; if (sck_v[1] !== 1'b1) begin n_bad++; $display("FAIL mode3_end_sck: got %b want 1", sck_v[1]); end
  endtask

  initial begin
    rst = 1'b1; cmd = '0; nbytes = '0; wdata = '0;
    for (int u = 0; u < 2; u++) begin
      go_v[u] = 1'b0; resp[u] = '0; mosi[u] = '0; idx[u] = 0; edges[u] = 0;
      done_cnt[u] = 0; hi_run[u] = 0; last_gap[u] = 0; prev_sck[u] = 1'(u); prev_csb[u] = 1'b1;
    end
    test_reset();
    test_chip_id();
    test_burst();
    test_write_clamp();
    test_random();
    test_handshake();
    test_abort_mode3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
